// File: rtl/pipeline_reg.sv
// -----------------------------------------------------------------------------
// pipeline_reg
//
// Purpose:
//   Single-stage, full-throughput register slice for a valid/ready stream.
//   It breaks the combinational paths on data, valid and ready between a
//   producer and a consumer. A main register drives the outputs directly and
//   a one-word skid register absorbs the word that the producer may already
//   have committed when the consumer stalls. Together the two registers
//   sustain one transfer per clock with no bubbles.
//
// Ports:
//   clk        in   1      clock, all state updates on rising edge
//   rstn       in   1      synchronous reset, active-high (1 = in reset)
//   in_valid   in   1      upstream offers in_data
//   in_data    in   width  upstream payload
//   in_ready   out  1      block can accept a word this cycle
//   out_valid  out  1      out_data holds a valid word
//   out_data   out  width  downstream payload
//   out_ready  in   1      downstream accepts the word this cycle
// -----------------------------------------------------------------------------
module pipeline_reg #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    input  logic [width-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [width-1:0] out_data,
    input  logic             out_ready
);

    // Main register (drives the outputs) and skid register.
    logic             r_out_valid;
    logic [width-1:0] r_out_data;
    logic             r_skid_valid;
    logic [width-1:0] r_skid_data;

    // Next-state values.
    logic             w_out_valid_nxt;
    logic [width-1:0] w_out_data_nxt;
    logic             w_skid_valid_nxt;
    logic [width-1:0] w_skid_data_nxt;

    logic             w_in_fire;
    logic             w_out_fire;

    // in_ready comes straight from the skid flop; it is only gated by reset,
    // so it never depends on in_valid or out_ready.
    assign in_ready   = ~r_skid_valid & ~rstn;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = r_out_valid & out_ready;

    // Next-state logic for the main and skid registers.
    always_comb begin
        w_out_valid_nxt  = r_out_valid;
        w_out_data_nxt   = r_out_data;
        w_skid_valid_nxt = r_skid_valid;
        w_skid_data_nxt  = r_skid_data;

        if (!r_out_valid || w_out_fire) begin
            // Main slot is free this edge. The skid word is older than
            // anything on the input, so it always moves first. While the
            // skid is full in_ready is low, so no input can be lost here.
            if (r_skid_valid) begin
                w_out_data_nxt   = r_skid_data;
                w_out_valid_nxt  = 1'b1;
                w_skid_valid_nxt = 1'b0;
            end else if (w_in_fire) begin
                w_out_data_nxt   = in_data;
                w_out_valid_nxt  = 1'b1;
            end else begin
                // Nothing to send: drop valid, keep the last data value.
                w_out_valid_nxt  = 1'b0;
            end
        end else begin
            // Main is full and stalled: hold it, park any accepted word.
            if (w_in_fire) begin
                w_skid_data_nxt  = in_data;
                w_skid_valid_nxt = 1'b1;
            end else begin
                w_skid_valid_nxt = r_skid_valid;
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= {width{1'b0}};
            r_skid_valid <= 1'b0;
            r_skid_data  <= {width{1'b0}};
        end else begin
            r_out_valid  <= w_out_valid_nxt;
            r_out_data   <= w_out_data_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_skid_data  <= w_skid_data_nxt;
        end
    end

endmodule

// File: tb/tb_pipeline_reg.sv
module tb_pipeline_reg;

    localparam int W = 32;

    logic         clk;
    logic         rstn;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] sb[$];
    logic         chk_stall = 1'b0;
    logic [W-1:0] stall_data = '0;

    pipeline_reg #(.width(W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: sees pre-edge values at each rising edge.
    always @(posedge clk) begin
        if (chk_stall) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== stall_data) begin
                failures++;
                $display("FAIL stall_stable: got valid=%b data=%h, want valid=1 data=%h",
                         out_valid, out_data, stall_data);
            end
        end
        chk_stall  = (rstn === 1'b0) && (out_valid === 1'b1) && (out_ready === 1'b0);
        stall_data = out_data;
        if (rstn !== 1'b0) begin
            sb.delete();
        end else begin
            if (in_valid === 1'b1 && in_ready === 1'b1) sb.push_back(in_data);
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_spurious: got data=%h, want no word", out_data);
                end else begin
                    logic [W-1:0] exp;
                    exp = sb.pop_front();
                    if (out_data !== exp) begin
                        failures++;
                        $display("FAIL sb_order: got data=%h, want %h", out_data, exp);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; out_ready = 1'b1;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got v=%b d=%h r=%b, want v=0 d=0 r=0",
                     out_valid, out_data, in_ready);
        end
        in_valid = 1'b0;
        rstn = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got r=%b v=%b, want r=1 v=0", in_ready, out_valid);
        end
    endtask

    task automatic test_single_stall();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1111_1111;
        step();
        in_valid = 1'b0; in_data = 32'h5555_5555;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'h1111_1111) begin
                failures++;
                $display("FAIL single_hold: cycle %0d got v=%b d=%h, want v=1 d=11111111",
                         i, out_valid, out_data);
            end
            if (i < 3) step();
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            failures++;
            $display("FAIL single_consume: got v=%b pending=%0d, want v=0 pending=0",
                     out_valid, sb.size());
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h2222_2222;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h2222_2222) begin
            failures++;
            $display("FAIL b2b_first: got v=%b d=%h, want v=1 d=22222222", out_valid, out_data);
        end
        in_data = 32'h3333_3333;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h3333_3333 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second: got v=%b d=%h r=%b, want v=1 d=33333333 r=1",
                     out_valid, out_data, in_ready);
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_empty: got v=%b, want 0", out_valid);
        end
    endtask

    task automatic test_skid_fill();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL skid_ready1: got %b, want 1", in_ready);
        end
        in_data = 32'hB;
        step();
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL skid_full: got in_ready=%b, want 0", in_ready);
        end
        in_data = 32'hC;
        step();
        checks++;
        if (in_ready !== 1'b0 || out_data !== 32'hA) begin
            failures++;
            $display("FAIL skid_hold: got r=%b d=%h, want r=0 d=a", in_ready, out_data);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_data !== 32'hB || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL skid_drain: got d=%h r=%b, want d=b r=1", out_data, in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hC) begin
            failures++;
            $display("FAIL skid_third: got v=%b d=%h, want v=1 d=c", out_valid, out_data);
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            failures++;
            $display("FAIL skid_done: got v=%b pending=%0d, want v=0 pending=0",
                     out_valid, sb.size());
        end
    endtask

    task automatic test_random();
        logic [W-1:0] payload;
        logic         fire;
        payload = 32'h1000_0000;
        for (int i = 0; i < 10000; i++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 55);
            in_data   = in_valid ? payload : 32'hFFFF_FFFF;
            #1;
            fire = in_valid & in_ready;
            step();
            if (fire) payload = payload + 32'd1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL random_drain: got pending=%0d v=%b, want 0 and 0", sb.size(), out_valid);
        end
    endtask

    task automatic test_midreset();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h7777_0001;
        step();
        in_data = 32'h7777_0002;
        step();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL midrst_full: got r=%b v=%b, want r=0 v=1", in_ready, out_valid);
        end
        rstn = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL midrst_clear: got v=%b d=%h r=%b, want v=0 d=0 r=0",
                     out_valid, out_data, in_ready);
        end
        rstn = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL midrst_stale: cycle %0d got v=%b r=%b, want v=0 r=1",
                         i, out_valid, in_ready);
            end
        end
    endtask

    initial begin
        rstn = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        test_reset();
        test_single_stall();
        test_back_to_back();
        test_skid_fill();
        test_random();
        test_midreset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
